// File: rtl/risc_v_mike_fetch_controller.sv
// Instruction fetch front end: sequential prefetch into a small queue toward decode,
// with redirect handling and a sticky fault for illegal fetch addresses.
module risc_v_mike_fetch_controller #(
  parameter int unsigned FIFO_DEPTH               = 2,
  parameter logic [31:0] MEM_MAP_TEXT_LOWER_LIMIT = 32'h0000_1000,
  parameter logic [31:0] RESET_PC                 = MEM_MAP_TEXT_LOWER_LIMIT,
  parameter int unsigned TEXT_WORDS               = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned OCC_W      = CNT_W + 1;
  localparam logic [31:0] TEXT_BYTES = 32'(TEXT_WORDS * 4);

  typedef enum logic {RUN, FAULT} state_e;

  state_e             state_q;
  logic [31:0]        fetch_pc_q;
  logic               inflight_q;
  logic [31:0]        inflight_pc_q;
  logic [31:0]        instr_q [FIFO_DEPTH];
  logic [31:0]        pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [31:0]        fault_pc_q;

  logic               fetch_legal;
  logic               redirect_legal;
  logic               push;
  logic               pop;
  logic [OCC_W-1:0]   occupancy;

  // Legal iff word aligned and inside the text window (unsigned wrap-around offset).
  function automatic logic is_legal(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - MEM_MAP_TEXT_LOWER_LIMIT;
    return (pc[1:0] == 2'b00) && (off < TEXT_BYTES);
  endfunction

  assign fetch_legal    = is_legal(fetch_pc_q);
  assign redirect_legal = is_legal(redirect_pc);

  assign dec_valid = !rst && (count_q != '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign push      = !rst && inflight_q && !redirect_valid;
  assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  // Credit check counts the in-flight response so a push can never hit a full queue.
  assign imem_req = !rst && (state_q == RUN) && fetch_legal && !redirect_valid &&
                    (occupancy < OCC_W'(FIFO_DEPTH));

  assign imem_addr   = rst ? RESET_PC : fetch_pc_q;
  assign dec_instr   = rst ? '0 : instr_q[rd_ptr_q];
  assign dec_pc      = rst ? '0 : pc_q[rd_ptr_q];
  assign fetch_fault = !rst && (state_q == FAULT);
  assign fault_pc    = rst ? '0 : fault_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      instr_q       <= '{default: '0};
      pc_q          <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fault_pc_q    <= '0;
    end else if (redirect_valid) begin
      // Redirect flushes everything, including a coincident push or pop.
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      if (redirect_legal) begin
        state_q <= RUN;
      end else begin
        state_q    <= FAULT;
        fault_pc_q <= redirect_pc;
      end
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        fetch_pc_q    <= fetch_pc_q + 32'd4;
        inflight_pc_q <= fetch_pc_q;
      end
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rd_data;
        pc_q[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      // Queue and in-flight response keep draining after the fault is raised.
      if (state_q == RUN && !fetch_legal) begin
        state_q    <= FAULT;
        fault_pc_q <= fetch_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_risc_v_mike_fetch_controller.sv
// Directed bench for the fetch controller; an in-order scoreboard tracks every
// non-squashed fetch and checks it against what decode receives.
module tb_risc_v_mike_fetch_controller;

  localparam logic [31:0] RESET_PC   = 32'h0000_1000;
  localparam int unsigned TEXT_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];

  risc_v_mike_fetch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  // One-cycle-latency instruction memory; a poison word when no fetch was issued.
  always @(posedge clk) imem_rd_data <= imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, run the scoreboard, then advance to the next negedge.
  task automatic tick();
    logic [31:0] e;
    #1;
    if (dec_valid && dec_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%h expected=none", dec_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", dec_pc, e);
        chk("sb_instr", dec_instr, word_of(e));
        delivered++;
      end
    end
    if (rst || redirect_valid) exp_q.delete();
    else if (imem_req) exp_q.push_back(imem_addr);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic got;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    @(negedge clk);
    tick();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    tick();

    // Streaming: one fetch per cycle from RESET_PC upward.
    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    chk("first_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    chk("seq_addr1", imem_addr, RESET_PC + 32'd4);
    tick();
    chk("seq_addr2", imem_addr, RESET_PC + 32'd8);
    delivered = 0;
    run(10);
    chk("stream_rate", 32'(delivered), 32'd10);

    // Back-pressure: queue fills, fetching stops, head holds.
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 32'(dec_valid), 32'd1);
      chk("stall_head", dec_pc, exp_q[0]);
      tick();
    end
    chk("stall_req", 32'(imem_req), 32'd0);
    dec_ready = 1'b1;
    run(8);

    // Redirect with entries queued and a response in flight.
    redirect_valid = 1'b1; redirect_pc = RESET_PC + 32'h40;
    #1;
    chk("redir_dec_valid", 32'(dec_valid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_addr", imem_addr, RESET_PC + 32'h40);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      if (dec_valid) begin
        got = 1'b1;
        chk("redir_first_pc", dec_pc, RESET_PC + 32'h40);
      end else tick();
    end
    chk("redir_got", 32'(got), 32'd1);
    run(4);

    // Misaligned redirect faults; legal redirect recovers.
    redirect_valid = 1'b1; redirect_pc = RESET_PC + 32'h2;
    tick();
    redirect_valid = 1'b0;
    run(1);
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_fault_pc", fault_pc, RESET_PC + 32'h2);
    chk("mis_req", 32'(imem_req), 32'd0);
    run(2);
    chk("mis_sticky", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1; redirect_pc = RESET_PC;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("recover_fault", 32'(fetch_fault), 32'd0);
    chk("recover_req", 32'(imem_req), 32'd1);
    chk("recover_addr", imem_addr, RESET_PC);
    run(6);

    // Run off the top of text: two last words delivered, then fault.
    delivered = 0;
    redirect_valid = 1'b1; redirect_pc = RESET_PC + 32'((TEXT_WORDS - 2) * 4);
    tick();
    redirect_valid = 1'b0;
    run(6);
    chk("top_delivered", 32'(delivered), 32'd2);
    chk("top_fault", 32'(fetch_fault), 32'd1);
    chk("top_fault_pc", fault_pc, RESET_PC + 32'(TEXT_WORDS * 4));
    chk("top_req", 32'(imem_req), 32'd0);
    chk("top_dec_valid", 32'(dec_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = RESET_PC + 32'h100;
    tick();
    redirect_valid = 1'b0;
    run(6);

    // Reset mid-stream with the queue busy and a fetch in flight.
    dec_ready = 1'b0;
    run(1);
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_dec_valid", 32'(dec_valid), 32'd0);
    chk("mrst_dec_pc", dec_pc, 32'd0);
    chk("mrst_addr", imem_addr, RESET_PC);
    tick();
    rst = 1'b0; dec_ready = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("post_rst_fault", 32'(fetch_fault), 32'd0);
    tick();
    #1;
    chk("post_rst_no_push", 32'(dec_valid), 32'd0);
    delivered = 0;
    run(6);
    chk("post_rst_stream", 32'(delivered), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
